avr_adc_spi_rx: RTL and testbench
=================================

# avr_adc_spi_rx

Receives 10-bit ADC samples that the AVR pushes over its SPI master link and buffers them in a small FIFO for the Picoblaze. Sits directly upstream of the Picoblaze input multiplexer: its data and status bytes are routed onto input ports, and it drives the ADC channel select back to the AVR. Also owns `spiMiso` and `spiChannel`, replacing their tie-off to high-Z.

## Interface
- `FIFO_AW`, 2, FIFO address width; depth = 2**FIFO_AW entries of 16 bits
- `SYNC_STAGES`, 2, synchronizer flops on `spiSs`/`spiSck`/`spiMosi` (≥2)
- `clk`  in  1  system clock (50 MHz)
- `nRst`  in  1  reset, asynchronous, active-low
- `spiSs`  in  1  SPI slave select from AVR, active-low
- `spiSck`  in  1  SPI clock from AVR (mode 0)
- `spiMosi`  in  1  SPI data AVR→FPGA, MSB first
- `spiMiso`  out  1  driven 0 while `spiSs` low, else 1'bz
- `spiChannel`  out  4  ADC channel request to AVR; 4'hF = sampling disabled
- `chanSel`  in  4  new channel value (from Picoblaze `outPort[3:0]`)
- `chanWrite`  in  1  one-cycle strobe: load `chanSel` into `spiChannel`
- `pop`  in  1  one-cycle strobe: discard FIFO head (Picoblaze read of high byte)
- `clrErr`  in  1  one-cycle strobe: clear sticky error flags
- `sampleLo`  out  8  FIFO head bits [7:0] (sample[7:0])
- `sampleHi`  out  8  FIFO head bits [15:8] ({chan[3:0], 2'b00, sample[9:8]})
- `status`  out  8  {overflow, frameErr, sampleValid, full, 1'b0, count[2:0]}
- `sampleValid`  out  1  FIFO not empty

## Operation
- Synchronize `spiSs`, `spiSck`, `spiMosi` through `SYNC_STAGES` flops each; detect `spiSck` rising edge from last two synced stages; sample synced `spiMosi` on that edge (equal delay on both).
- Armed flag: cleared by reset; set on first synced `spiSs` high. Capture only when armed; reset mid-frame therefore discards the partial frame and waits for `spiSs` to rise and fall again.
- Synced `spiSs` falling edge: clear shift register and 4-bit bit counter.
- Each rising `spiSck` while `spiSs` low: shift left, counter +1 (wraps 15→0). Multiple 16-bit frames per `spiSs` assertion allowed.
- Frame = 16 bits: first byte on wire → entry[7:0], second byte → entry[15:8]. Counter wrap to 0 = frame complete → push request.
- Push when not full; push when full and no pop same cycle → entry dropped, `overflow` set. Push+pop same cycle when full → both performed, count unchanged, no overflow. Pop when empty → ignored. Push+pop when empty → push only.
- Synced `spiSs` rising with counter ≠ 0 → partial frame discarded, `frameErr` set.
- `clrErr` clears both sticky flags; an error event in the same cycle wins (flag stays set).
- Received channel field not checked against `spiChannel` (AVR lags a request by one conversion); stored as received.
- `chanWrite` loads `spiChannel` next cycle; does not flush FIFO.
- Outputs `sampleLo`/`sampleHi` show FIFO head combinationally from storage; undefined content masked to 0 when empty.
- `count` = occupancy, 0..2**FIFO_AW; width 3 bits at default (FIFO_AW+1 in general, `status` shows low 3 bits).

## Timing
- Reset values: `spiChannel`=4'hF, `status`=8'h00, `sampleValid`=0, `sampleLo`/`sampleHi`=0, `spiMiso`=z, FIFO empty, flags clear.
- `spiSck` pin edge → internal edge detect: SYNC_STAGES+1 clk cycles.
- 16th detected rising edge → `sampleValid`/`count` update: 1 cycle.
- `pop` → new head on `sampleLo`/`sampleHi` and `count` decremented: next cycle.
- `spiMiso` follows synced `spiSs` (SYNC_STAGES cycles latency).
- Requirement: `spiSck` high and low phases each ≥ 2 clk periods; `spiSs` high gap ≥ SYNC_STAGES+2 clk periods.

## Test plan
- Reset, `spiSs` high, two-byte frame 8'hA5 then 8'h23 → `sampleValid`=1, `sampleLo`=8'hA5, `sampleHi`=8'h23, `status`=8'h21.
- Five frames back-to-back in one `spiSs` assertion, no pops → `count`=4, `full`=1, `overflow`=1, head = first frame; four pops drain in order, `sampleValid`=0.
- Frame aborted after 9 bits (`spiSs` rises) → FIFO unchanged, `frameErr`=1; `clrErr` → `status[6]`=0; `clrErr` coinciding with next abort → stays 1.
- FIFO full, frame completes same cycle as `pop` → `count` stays 4, `overflow`=0, new entry at tail.
- `chanWrite` with `chanSel`=4'h3 → `spiChannel`=4'h3 next cycle; reset → 4'hF.
- Assert `nRst` low at bit 7 with `spiSs` held low, release, clock 16 more bits → no push; `spiSs` high then low, full frame → one push.

Source files
------------

// File: rtl/avr_adc_spi_rx.sv
// avr_adc_spi_rx: SPI slave receiving 16-bit ADC frames from the AVR into a small FIFO for the Picoblaze.
module avr_adc_spi_rx #(
  parameter int FIFO_AW     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       spiSs,
  input  logic       spiSck,
  input  logic       spiMosi,
  output logic       spiMiso,
  output logic [3:0] spiChannel,
  input  logic [3:0] chanSel,
  input  logic       chanWrite,
  input  logic       pop,
  input  logic       clrErr,
  output logic [7:0] sampleLo,
  output logic [7:0] sampleHi,
  output logic [7:0] status,
  output logic       sampleValid
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = FIFO_AW + 1;
  logic [SYNC_STAGES-1:0] ss_q, sck_q, mosi_q, rv_q;
  logic ss_d1_q, sck_d1_q, armed_q, ovf_q, ferr_q;
  logic [15:0] shift_q, shift_d, frame;
  logic [3:0] bit_q, bit_d, chan_q;
  logic [15:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ss_s, sck_rise, ss_fall, ss_rise, shift_en, push;
  logic full, empty, pop_ok, push_ok, ovf_ev, ferr_ev;
  logic [2:0] cnt3;
  // rv_q marks when the ss chain holds real pin samples rather than reset fill
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d1_q;
  assign ss_fall  = armed_q & ss_d1_q & ~ss_s;
  assign ss_rise  = armed_q & ~ss_d1_q & ss_s;
  assign shift_en = armed_q & ~ss_s & sck_rise;
  assign frame    = {shift_q[14:0], mosi_q[SYNC_STAGES-1]};
  assign push     = shift_en & (bit_q == 4'hF);
  assign shift_d  = ss_fall ? 16'h0 : shift_en ? frame : shift_q;
  assign bit_d    = ss_fall ? 4'h0 : shift_en ? bit_q + 4'h1 : bit_q;
  assign ferr_ev  = ss_rise & (bit_q != 4'h0);
  assign full     = cnt_q == CW'(DEPTH);
  assign empty    = cnt_q == '0;
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign ovf_ev   = push & ~push_ok;
  assign cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
  assign cnt3     = 3'(cnt_q);
  assign spiMiso  = ss_s ? 1'bz : 1'b0;
  assign spiChannel  = chan_q;
  assign sampleValid = ~empty;
  assign sampleLo    = empty ? 8'h00 : mem_q[rp_q][7:0];
  assign sampleHi    = empty ? 8'h00 : mem_q[rp_q][15:8];
  assign status      = {ovf_q, ferr_q, ~empty, full, 1'b0, cnt3};
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ss_q     <= '1;
      sck_q    <= '0;
      mosi_q   <= '0;
      rv_q     <= '0;
      ss_d1_q  <= 1'b1;
      sck_d1_q <= 1'b0;
      armed_q  <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      chan_q   <= 4'hF;
    end else begin
      ss_q     <= {ss_q[SYNC_STAGES-2:0], spiSs};
      sck_q    <= {sck_q[SYNC_STAGES-2:0], spiSck};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], spiMosi};
      rv_q     <= {rv_q[SYNC_STAGES-2:0], 1'b1};
      ss_d1_q  <= ss_s;
      sck_d1_q <= sck_q[SYNC_STAGES-1];
      armed_q  <= armed_q | (rv_q[SYNC_STAGES-1] & ss_s);
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      wp_q     <= wp_q + FIFO_AW'(push_ok);
      rp_q     <= rp_q + FIFO_AW'(pop_ok);
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_ev | (ovf_q & ~clrErr);
      ferr_q   <= ferr_ev | (ferr_q & ~clrErr);
      chan_q   <= chanWrite ? chanSel : chan_q;
    end
  end
  // first byte on the wire lands in the low half of the entry
  always_ff @(posedge clk)
    if (push_ok) mem_q[wp_q] <= {frame[7:0], frame[15:8]};
endmodule

// File: tb/tb_avr_adc_spi_rx.sv
// tb_avr_adc_spi_rx: directed scenario tests for avr_adc_spi_rx.
module tb_avr_adc_spi_rx;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic spiSs = 1'b1, spiSck = 1'b0, spiMosi = 1'b0;
  logic [3:0] chanSel = 4'h0;
  logic chanWrite = 1'b0, pop = 1'b0, clrErr = 1'b0;
  wire spiMiso;
  logic [3:0] spiChannel;
  logic [7:0] sampleLo, sampleHi, status;
  logic sampleValid;
  int tests = 0;
  int fails = 0;

  avr_adc_spi_rx dut (
    .clk(clk), .nRst(nRst), .spiSs(spiSs), .spiSck(spiSck), .spiMosi(spiMosi),
    .spiMiso(spiMiso), .spiChannel(spiChannel), .chanSel(chanSel), .chanWrite(chanWrite),
    .pop(pop), .clrErr(clrErr), .sampleLo(sampleLo), .sampleHi(sampleHi),
    .status(status), .sampleValid(sampleValid)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pop_at_rise pulses pop exactly on the cycle the rising edge is acted on
  task automatic send_bit(input logic b, input logic pop_at_rise);
    spiMosi = b;
    tick(3);
    spiSck = 1'b1;
    if (pop_at_rise) begin
      tick(2);
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
    end else tick(3);
    spiSck = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi, input logic pop_last);
    for (int i = 7; i >= 0; i--) send_bit(lo[i], 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(hi[i], 1'b0);
    send_bit(hi[0], pop_last);
    tick(3);
  endtask

  task automatic ss_lo();
    spiSs = 1'b0;
    tick(4);
  endtask

  task automatic ss_hi();
    spiSs = 1'b1;
    tick(6);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  task automatic do_clr();
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    spiSs = 1'b1;
    tick(2);
    tests++; if (spiChannel !== 4'hF) begin fails++; $display("FAIL reset_chan got %h exp f", spiChannel); end
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL reset_status got %h exp 00", status); end
    tests++; if (sampleValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", sampleValid); end
    tests++; if ({sampleHi, sampleLo} !== 16'h0000) begin fails++; $display("FAIL reset_head got %h exp 0000", {sampleHi, sampleLo}); end
    nRst = 1'b1;
    tick(6);
  endtask

  task automatic test_single();
    ss_lo();
    tests++; if (spiMiso !== 1'b0) begin fails++; $display("FAIL miso_low got %b exp 0", spiMiso); end
    send_frame(8'hA5, 8'h23, 1'b0);
    tests++; if (sampleValid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", sampleValid); end
    tests++; if (sampleLo !== 8'hA5) begin fails++; $display("FAIL single_lo got %h exp a5", sampleLo); end
    tests++; if (sampleHi !== 8'h23) begin fails++; $display("FAIL single_hi got %h exp 23", sampleHi); end
    tests++; if (status !== 8'h21) begin fails++; $display("FAIL single_status got %h exp 21", status); end
    ss_hi();
    do_pop();
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL single_pop_status got %h exp 00", status); end
    do_pop();
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL pop_empty_status got %h exp 00", status); end
  endtask

  task automatic test_back_to_back();
    ss_lo();
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 8'h80 + 8'(i), 1'b0);
    tests++; if (status !== 8'hB4) begin fails++; $display("FAIL b2b_status got %h exp b4", status); end
    tests++; if (sampleLo !== 8'h10) begin fails++; $display("FAIL b2b_head_lo got %h exp 10", sampleLo); end
    ss_hi();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({sampleHi, sampleLo} !== {8'h80 + 8'(i), 8'h10 + 8'(i)}) begin
        fails++; $display("FAIL b2b_drain%0d got %h exp %h", i, {sampleHi, sampleLo}, {8'h80 + 8'(i), 8'h10 + 8'(i)});
      end
      do_pop();
    end
    tests++; if (status !== 8'h80) begin fails++; $display("FAIL b2b_drained got %h exp 80", status); end
    do_clr();
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL b2b_clr got %h exp 00", status); end
  endtask

  task automatic test_frame_err();
    ss_lo();
    for (int i = 0; i < 9; i++) send_bit(i[0], 1'b0);
    ss_hi();
    tests++; if (status !== 8'h40) begin fails++; $display("FAIL ferr_status got %h exp 40", status); end
    do_clr();
    tests++; if (status[6] !== 1'b0) begin fails++; $display("FAIL ferr_clr got %b exp 0", status[6]); end
    ss_lo();
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
    spiSs = 1'b1;
    tick(1);
    clrErr = 1'b1;
    tick(2);
    clrErr = 1'b0;
    tests++; if (status !== 8'h40) begin fails++; $display("FAIL ferr_clr_race got %h exp 40", status); end
    tick(4);
    do_clr();
  endtask

  task automatic test_full_pop();
    ss_lo();
    for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 8'hC0 + 8'(i), 1'b0);
    tests++; if (status !== 8'h34) begin fails++; $display("FAIL full_status got %h exp 34", status); end
    send_frame(8'h44, 8'hC4, 1'b1);
    tests++; if (status !== 8'h34) begin fails++; $display("FAIL full_pop_status got %h exp 34", status); end
    ss_hi();
    for (int i = 1; i < 5; i++) begin
      tests++;
      if ({sampleHi, sampleLo} !== {8'hC0 + 8'(i), 8'h40 + 8'(i)}) begin
        fails++; $display("FAIL full_drain%0d got %h exp %h", i, {sampleHi, sampleLo}, {8'hC0 + 8'(i), 8'h40 + 8'(i)});
      end
      do_pop();
    end
    tests++; if (sampleValid !== 1'b0) begin fails++; $display("FAIL full_empty got %b exp 0", sampleValid); end
  endtask

  task automatic test_chan();
    chanSel = 4'h3;
    chanWrite = 1'b1;
    tick(1);
    chanWrite = 1'b0;
    chanSel = 4'h9;
    tests++; if (spiChannel !== 4'h3) begin fails++; $display("FAIL chan_load got %h exp 3", spiChannel); end
    tick(1);
    tests++; if (spiChannel !== 4'h3) begin fails++; $display("FAIL chan_hold got %h exp 3", spiChannel); end
  endtask

  task automatic test_reset_midframe();
    ss_lo();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    nRst = 1'b0;
    tick(2);
    tests++; if (spiChannel !== 4'hF) begin fails++; $display("FAIL rst_chan got %h exp f", spiChannel); end
    nRst = 1'b1;
    tick(2);
    send_frame(8'hFF, 8'h11, 1'b0);
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL rst_nopush got %h exp 00", status); end
    ss_hi();
    ss_lo();
    send_frame(8'h5A, 8'h3C, 1'b0);
    tests++; if (status !== 8'h21) begin fails++; $display("FAIL rst_push_status got %h exp 21", status); end
    tests++; if ({sampleHi, sampleLo} !== 16'h3C5A) begin fails++; $display("FAIL rst_push_head got %h exp 3c5a", {sampleHi, sampleLo}); end
    ss_hi();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_full_pop();
    test_chan();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
